// File: rtl/noc_pkg.sv
// rtl/noc_pkg.sv - shared NoC flit layout, header field positions and tx FSM states
package noc_pkg;

  localparam int FLIT_W    = 128;
  localparam int COORD_W   = 16;
  localparam int LEN_W     = 3;

  localparam int DST_X_LSB = 48;
  localparam int DST_Y_LSB = 32;
  localparam int SRC_X_LSB = 16;
  localparam int SRC_Y_LSB = 0;
  localparam int LEN_LSB   = 64;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    SEND
  } tx_state_t;

  function automatic logic [LEN_W-1:0] flit_len(input logic [FLIT_W-1:0] f);
    return f[LEN_LSB +: LEN_W];
  endfunction

  function automatic logic [2*COORD_W-1:0] flit_dst(input logic [FLIT_W-1:0] f);
    return {f[DST_X_LSB +: COORD_W], f[DST_Y_LSB +: COORD_W]};
  endfunction

  // Only the source field changes; every other header bit passes through.
  function automatic logic [FLIT_W-1:0] stamp_src(input logic [FLIT_W-1:0] f,
                                                  input logic [COORD_W-1:0] x,
                                                  input logic [COORD_W-1:0] y);
    logic [FLIT_W-1:0] r;
    r = f;
    r[SRC_X_LSB +: COORD_W] = x;
    r[SRC_Y_LSB +: COORD_W] = y;
    return r;
  endfunction

endpackage

// File: rtl/noc_fifo.sv
// rtl/noc_fifo.sv - single-clock FIFO with head and next-head read ports
module noc_fifo #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic [WIDTH-1:0]           rdata_next,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    rd_ptr_next;
  logic             do_push;
  logic             do_pop;

  assign full        = (count == CW'(DEPTH));
  assign empty       = (count == '0);
  assign do_push     = push & ~full;
  assign do_pop      = pop & ~empty;
  assign rd_ptr_next = rd_ptr + 1'b1;
  assign rdata       = mem[rd_ptr];
  assign rdata_next  = mem[rd_ptr_next];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr_next;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/noc_port_tx.sv
// rtl/noc_port_tx.sv - local-injection transmitter feeding one switch input lane
module noc_port_tx
  import noc_pkg::*;
#(
  parameter int X     = 1,
  parameter int Y     = 1,
  parameter int DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [FLIT_W-1:0] in_data,
  output logic              have_data,
  input  logic              read_enable,
  output logic [FLIT_W-1:0] data_out,
  output logic              is_writing,
  output logic [3:0]        pkt_pending
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [COORD_W-1:0] SRC_X = COORD_W'(X);
  localparam logic [COORD_W-1:0] SRC_Y = COORD_W'(Y);

  logic [LEN_W-1:0]  in_cnt;
  logic [LEN_W-1:0]  in_len;
  logic              is_hdr;
  logic              accept;
  logic              in_last;
  logic              last_q;
  logic [FLIT_W-1:0] wr_flit;

  logic [FLIT_W-1:0] head;
  logic [FLIT_W-1:0] head_next;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CW-1:0]     fifo_count;

  tx_state_t         state;
  logic [LEN_W-1:0]  rem;
  logic              pop;
  logic              pkt_done;
  logic [3:0]        pend_next;

  assign in_ready = ~fifo_full;
  assign accept   = in_valid & in_ready;
  assign is_hdr   = (in_cnt == '0);
  assign in_last  = is_hdr ? (flit_len(in_data) == '0) : (in_cnt == in_len);
  assign wr_flit  = is_hdr ? stamp_src(in_data, SRC_X, SRC_Y) : in_data;

  noc_fifo #(
    .WIDTH (FLIT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (accept),
    .wdata      (wr_flit),
    .pop        (pop),
    .rdata      (head),
    .rdata_next (head_next),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .count      (fifo_count)
  );

  // Packet position on the write side; in_cnt==0 means the next flit is a header.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_cnt <= '0;
      in_len <= '0;
      last_q <= 1'b0;
    end else begin
      last_q <= accept & in_last;
      if (accept) begin
        if (in_last) begin
          in_cnt <= '0;
        end else begin
          in_cnt <= in_cnt + 1'b1;
          if (is_hdr) in_len <= flit_len(in_data);
        end
      end
    end
  end

  assign pop       = (state == SEND) & read_enable & (fifo_count != '0);
  assign pkt_done  = pop & (rem == '0);
  assign pend_next = pkt_pending + {3'b000, last_q} - {3'b000, pkt_done};

  // A packet counts as pending one edge after its last flit lands, so the
  // FSM only ever sees packets that are wholly inside the FIFO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pkt_pending <= '0;
    else     pkt_pending <= pend_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      rem        <= '0;
      have_data  <= 1'b0;
      is_writing <= 1'b0;
      data_out   <= '0;
    end else begin
      case (state)
        IDLE: begin
          is_writing <= 1'b0;
          if (pkt_pending != '0 && !fifo_empty) begin
            state     <= REQ;
            have_data <= 1'b1;
          end
        end
        REQ: begin
          have_data <= 1'b1;
          if (read_enable) begin
            state      <= SEND;
            rem        <= flit_len(head);
            data_out   <= head;
            is_writing <= 1'b1;
          end
        end
        SEND: begin
          if (pop) begin
            if (rem == '0) begin
              is_writing <= 1'b0;
              if (pend_next == '0) begin
                state     <= IDLE;
                have_data <= 1'b0;
              end else begin
                state <= REQ;
              end
            end else begin
              // The flit behind the one being popped becomes visible next cycle.
              rem        <= rem - 1'b1;
              data_out   <= head_next;
              is_writing <= 1'b1;
            end
          end else begin
            is_writing <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          have_data  <= 1'b0;
          is_writing <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/noc_port_tx.md
# noc_port_tx

Local-injection transmitter for one switch input port. Accepts flits from the local core, stamps the source address, buffers whole packets in a FIFO and delivers them to the switch through the `have_data` / `read_enable` / `is_writing` handshake. One instance drives each `data_in[i]`, `have_data[i]` and `is_writing_in[i]` lane of a switch.

## Interface
- `X`, default 1: this node's X coordinate, stamped into source address bits [31:16].
- `Y`, default 1: this node's Y coordinate, stamped into source address bits [15:0].
- `DEPTH`, default 8: FIFO depth in flits, power of two, ≥ 8.
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `in_valid` in 1: local flit valid.
- `in_ready` out 1: FIFO can accept a flit.
- `in_data` in 128: local flit.
- `have_data` out 1: a complete packet is waiting for the switch.
- `read_enable` in 1: switch grants and pulls flits.
- `data_out` out 128: flit to the switch.
- `is_writing` out 1: `data_out` is valid and granted.
- `pkt_pending` out 4: number of complete packets in the FIFO.

## Operation
- Flit format:
  - Header: [63:48] dst X, [47:32] dst Y, [31:16] src X, [15:0] src Y, [66:64] LEN (body flits following, 0–7).
  - Body flits are opaque.
- Write side:
  - A flit is accepted when `in_valid & in_ready`.
  - An input counter tracks the header/body position.
  - On a header flit, [31:0] is overwritten with {X[15:0], Y[15:0]} before storing. Other bits are unchanged.
  - `in_ready = !full`.
  - The last flit of a packet (header with LEN=0, or body flit LEN) increments `pkt_pending`.
- FSM states:
  - IDLE → REQ when `pkt_pending` > 0.
  - REQ: `have_data=1`. Waits for `read_enable` sampled high at a posedge, then → SEND. A remaining-flit counter is loaded with the head LEN.
  - SEND: `is_writing=1`, `data_out` = FIFO head.
    - Each posedge with `read_enable=1` pops one flit and decrements the counter.
    - At the posedge that pops the last flit → IDLE if `pkt_pending` after decrement is 0, else → REQ.
    - `have_data` stays 1 throughout SEND.
- Pause: if `read_enable` is low at a posedge in SEND, there is no pop, the state stays SEND and `is_writing` drops to 0 until `read_enable` returns.
- A packet is never interleaved. Send order is FIFO order.
- Simultaneous push and pop in one cycle is legal. `pkt_pending` increments and decrements net to zero change.

## Timing
- Reset values: `have_data=0`, `is_writing=0`, `data_out=0`, `in_ready=1`, `pkt_pending=0`, FSM=IDLE, pointers and counters 0.
- Reset mid-packet discards all FIFO contents and the partial input packet.
- All outputs are registered except `in_ready`, which is combinational from the FIFO count.
- Latency:
  - Last input flit accepted at edge N → `have_data=1` after edge N+2 (N+1 sets `pkt_pending`, N+2 enters REQ).
  - `read_enable` high at edge M → header on `data_out` with `is_writing=1` after edge M.
  - Flits stream one per cycle while `read_enable` stays high.
- `is_writing = (state==SEND) & read_enable_q`, where `read_enable_q` is `read_enable` registered at the previous edge. `is_writing` is high in the first SEND cycle.
- FIFO full: `in_ready=0`, and the input is held by the source.
  - A packet larger than the free space stalls the write side until pops free space.
  - `DEPTH` ≥ 8 guarantees any single packet fits.
- Pointers wrap modulo `DEPTH`. The count uses `log2(DEPTH)+1` bits to distinguish full from empty.

## Structure
- Shared package `noc_pkg`:
  - Flit width 128.
  - Header field bit positions (DST_X, DST_Y, SRC_X, SRC_Y, LEN).
  - LEN width 3.
  - FSM state enum {IDLE, REQ, SEND}.
- Sub-module `noc_fifo`: synchronous single-clock FIFO with push/pop/full/empty/count, parameterised width and depth. The switch's future input buffers reuse it.

## Test plan
- Single header flit, dst (2,3), LEN=0, X=1, Y=1 → `have_data` rises 2 cycles after accept. After `read_enable`, `data_out[63:0]` = 0x0002_0003_0001_0001 with `is_writing`=1 for one cycle, then `have_data`=0.
- Header with LEN=3 plus 3 body flits, `read_enable` held high → 4 consecutive `is_writing` cycles in order, `pkt_pending` 1→0.
- Same packet with `read_enable` low for 2 cycles after the second flit → `is_writing` drops for 2 cycles, no flit is lost or duplicated, and the order is preserved.
- Push 8 flits without draining → `in_ready`=0 at count 8. One pop → `in_ready`=1 next cycle. Pointer wrap is exercised over 3 fill/drain rounds.
- Two back-to-back LEN=0 packets while sending → after the first pop, FSM returns to REQ and `have_data` never drops between packets.
- Assert `rst` mid-SEND of a LEN=5 packet → all outputs return to reset values immediately. A subsequent new packet is sent with no stale flits.
